// File: rtl/mr_retqueue.sv
// In-order retire queue: allocates instruction IDs, takes out-of-order completions,
// retires one per cycle and flushes on a mispredicted next PC. Optional macro: MR_RETQ_PERF_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTID_BITS
`define INSTID_BITS 3
`endif

module mr_retqueue #(
  parameter int                ID_BITS   = `INSTID_BITS,
  parameter logic [`XLEN-1:0]  RESET_VEC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_alloc,
  input  logic [`XLEN-1:0]     inst_alloc_pc,
  output logic                 inst_buffer_full,
  output logic [ID_BITS-1:0]   next_inst_id,
  input  logic                 cpl_valid,
  input  logic [ID_BITS-1:0]   cpl_id,
  input  logic [`XLEN-1:0]     cpl_next_pc,
  input  logic [4:0]           cpl_rd,
  input  logic                 cpl_rd_we,
  input  logic [`XLEN-1:0]     cpl_rd_val,
  output logic                 ret_valid,
  output logic [`XLEN-1:0]     ret_pc,
  output logic [4:0]           ret_rd,
  output logic                 ret_rd_we,
  output logic [`XLEN-1:0]     ret_rd_val,
  output logic [`XLEN-1:0]     wb_pc,
  output logic                 wb_pc_valid,
  output logic [ID_BITS:0]     occupancy
`ifdef MR_RETQ_PERF_EN
  ,
  output logic [63:0]          perf_retired,
  output logic [31:0]          perf_flushes
`endif
);

  localparam int DEPTH = 1 << ID_BITS;
  localparam int XL    = `XLEN;

  logic [ID_BITS:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]   done_q, done_d;

  logic [XL-1:0]      pc_mem  [DEPTH];
  logic [XL-1:0]      npc_mem [DEPTH];
  logic [XL-1:0]      val_mem [DEPTH];
  logic [4:0]         rd_mem  [DEPTH];
  logic [DEPTH-1:0]   we_mem;

  logic               ret_valid_q, ret_rd_we_q, wb_pc_valid_q;
  logic [XL-1:0]      ret_pc_q, ret_rd_val_q, wb_pc_q;
  logic [4:0]         ret_rd_q;

  logic [ID_BITS-1:0] head_idx, tail_idx, cpl_off;
  logic [ID_BITS:0]   occ;
  logic               full, empty, cpl_in_win, cpl_ok, alloc_ok, retire, redirect;

  assign head_idx   = head_q[ID_BITS-1:0];
  assign tail_idx   = tail_q[ID_BITS-1:0];
  assign occ        = tail_q - head_q;
  assign full       = (occ == (ID_BITS+1)'(DEPTH));
  assign empty      = (head_q == tail_q);
  // Window test: distance from head (mod DEPTH) must be below the live count.
  assign cpl_off    = cpl_id - head_idx;
  assign cpl_in_win = ({1'b0, cpl_off} < occ);
  assign cpl_ok     = cpl_valid & ~wb_pc_valid_q & cpl_in_win & ~done_q[cpl_id];
  assign retire     = ~empty & done_q[head_idx];
  assign redirect   = retire & (npc_mem[head_idx] != pc_mem[head_idx] + XL'(4));
  assign alloc_ok   = inst_alloc & ~full & ~wb_pc_valid_q & ~redirect;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    done_d = done_q;
    if (retire) begin
      head_d           = head_q + 1'b1;
      done_d[head_idx] = 1'b0;
    end
    if (cpl_ok)
      done_d[cpl_id] = 1'b1;
    if (alloc_ok) begin
      done_d[tail_idx] = 1'b0;
      tail_d           = tail_q + 1'b1;
    end
    if (redirect) begin
      done_d = '0;
      tail_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      done_q        <= '0;
      ret_valid_q   <= 1'b0;
      ret_rd_we_q   <= 1'b0;
      ret_pc_q      <= '0;
      ret_rd_q      <= '0;
      ret_rd_val_q  <= '0;
      wb_pc_valid_q <= 1'b0;
      wb_pc_q       <= RESET_VEC;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      done_q        <= done_d;
      ret_valid_q   <= retire;
      ret_rd_we_q   <= retire & we_mem[head_idx];
      wb_pc_valid_q <= redirect;
      if (retire) begin
        ret_pc_q     <= pc_mem[head_idx];
        ret_rd_q     <= rd_mem[head_idx];
        ret_rd_val_q <= val_mem[head_idx];
      end
      if (redirect)
        wb_pc_q <= npc_mem[head_idx];
    end
  end

  // Payload storage needs no reset: done bits gate every read.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (alloc_ok && tail_idx == ID_BITS'(gi))
        pc_mem[gi] <= inst_alloc_pc;
      if (cpl_ok && cpl_id == ID_BITS'(gi)) begin
        npc_mem[gi] <= cpl_next_pc;
        rd_mem[gi]  <= cpl_rd;
        we_mem[gi]  <= cpl_rd_we;
        val_mem[gi] <= cpl_rd_val;
      end
    end
  end

`ifdef MR_RETQ_PERF_EN
  logic [63:0] perf_retired_q;
  logic [31:0] perf_flushes_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_q + {63'd0, ret_valid_q};
      perf_flushes_q <= perf_flushes_q + {31'd0, wb_pc_valid_q};
    end
  end
  assign perf_retired = perf_retired_q;
  assign perf_flushes = perf_flushes_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(inst_alloc && full))
        else $warning("mr_retqueue: allocation while full ignored");
      assert (!(cpl_valid && !wb_pc_valid_q && cpl_in_win && done_q[cpl_id]))
        else $warning("mr_retqueue: completion of already-done entry ignored");
    end
  end
`endif

  assign inst_buffer_full = full;
  assign next_inst_id     = tail_idx;
  assign occupancy        = occ;
  assign ret_valid        = ret_valid_q;
  assign ret_pc           = ret_pc_q;
  assign ret_rd           = ret_rd_q;
  assign ret_rd_we        = ret_rd_we_q;
  assign ret_rd_val       = ret_rd_val_q;
  assign wb_pc            = wb_pc_q;
  assign wb_pc_valid      = wb_pc_valid_q;

endmodule

// File: tb/tb_mr_retqueue.sv
// Self-checking bench for mr_retqueue: directed scenarios plus random traffic
// compared against a queue-of-instructions reference model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mr_retqueue;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_alloc, cpl_valid, cpl_rd_we;
  logic [31:0] inst_alloc_pc, cpl_next_pc, cpl_rd_val;
  logic [2:0]  cpl_id;
  logic [4:0]  cpl_rd;
  logic        inst_buffer_full, ret_valid, ret_rd_we, wb_pc_valid;
  logic [2:0]  next_inst_id;
  logic [31:0] ret_pc, ret_rd_val, wb_pc;
  logic [4:0]  ret_rd;
  logic [3:0]  occupancy;
`ifdef MR_RETQ_PERF_EN
  logic [63:0] perf_retired;
  logic [31:0] perf_flushes;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mr_retqueue #(.ID_BITS(3), .RESET_VEC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .inst_alloc(inst_alloc), .inst_alloc_pc(inst_alloc_pc),
    .inst_buffer_full(inst_buffer_full), .next_inst_id(next_inst_id),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_next_pc(cpl_next_pc),
    .cpl_rd(cpl_rd), .cpl_rd_we(cpl_rd_we), .cpl_rd_val(cpl_rd_val),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_rd(ret_rd),
    .ret_rd_we(ret_rd_we), .ret_rd_val(ret_rd_val),
    .wb_pc(wb_pc), .wb_pc_valid(wb_pc_valid), .occupancy(occupancy)
`ifdef MR_RETQ_PERF_EN
    , .perf_retired(perf_retired), .perf_flushes(perf_flushes)
`endif
  );

  // Reference model: the live instructions in program order.
  typedef struct {
    logic [2:0]  id;
    logic [31:0] pc, npc, val;
    logic [4:0]  rd;
    logic        we, done;
  } ent_t;
  ent_t        mq[$];
  logic [2:0]  m_next_id;
  logic        m_ret_valid, m_ret_we, m_wb_valid;
  logic [31:0] m_ret_pc, m_ret_val, m_wb_pc;
  logic [4:0]  m_ret_rd;

  task automatic model_reset();
    mq.delete();
    m_next_id = 0; m_ret_valid = 0; m_ret_we = 0; m_wb_valid = 0;
    m_ret_pc = 0; m_ret_val = 0; m_ret_rd = 0; m_wb_pc = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit   ret, fl, wb_now;
    int   n;
    ent_t h, t;
    n = mq.size(); wb_now = m_wb_valid;
    ret = (n > 0) && mq[0].done;
    fl = 0;
    if (cpl_valid && !wb_now)
      for (int i = 0; i < n; i++)
        if (mq[i].id == cpl_id && !mq[i].done) begin
          t = mq[i];
          t.done = 1; t.npc = cpl_next_pc; t.rd = cpl_rd; t.we = cpl_rd_we; t.val = cpl_rd_val;
          mq[i] = t;
        end
    if (ret) begin
      h = mq.pop_front();
      fl = (h.npc != h.pc + 32'd4);
    end
    if (fl) begin
      mq.delete();
      m_next_id = h.id + 3'd1;
    end else if (inst_alloc && n < 8 && !wb_now) begin
      t = '{id: m_next_id, pc: inst_alloc_pc, npc: 0, val: 0, rd: 0, we: 0, done: 0};
      mq.push_back(t);
      m_next_id = m_next_id + 3'd1;
    end
    m_ret_valid = ret;
    m_ret_we = ret && h.we;
    if (ret) begin m_ret_pc = h.pc; m_ret_rd = h.rd; m_ret_val = h.val; end
    m_wb_valid = fl;
    if (fl) m_wb_pc = h.npc;
  endtask

  task automatic idle_inputs();
    inst_alloc = 0; inst_alloc_pc = 0; cpl_valid = 0; cpl_id = 0;
    cpl_next_pc = 0; cpl_rd = 0; cpl_rd_we = 0; cpl_rd_val = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic alloc(input logic [31:0] pc);
    inst_alloc = 1; inst_alloc_pc = pc;
    $display("alloc    id=%0d pc=%h", next_inst_id, pc);
    step();
  endtask

  task automatic complete(input logic [2:0] id, input logic [31:0] npc,
                          input logic [4:0] rd, input logic we, input logic [31:0] val);
    cpl_valid = 1; cpl_id = id; cpl_next_pc = npc; cpl_rd = rd; cpl_rd_we = we; cpl_rd_val = val;
    $display("complete id=%0d next_pc=%h rd=%0d we=%0d val=%h", id, npc, rd, we, val);
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (inst_buffer_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", inst_buffer_full); end
    checks++; if (wb_pc !== 32'h0 || wb_pc_valid !== 1'b0) begin failures++; $display("FAIL reset_wb got=%h/%b exp=0/0", wb_pc, wb_pc_valid); end
    checks++; if (ret_valid !== 1'b0 || ret_pc !== 32'h0 || ret_rd_val !== 32'h0) begin failures++; $display("FAIL reset_ret got=%b/%h/%h exp=0/0/0", ret_valid, ret_pc, ret_rd_val); end
    alloc(32'h10); alloc(32'h14); alloc(32'h18);
    checks++; if (occupancy !== 4'd3) begin failures++; $display("FAIL pre_reset_occ got=%0d exp=3", occupancy); end
    #2 rst = 1;
    #1;
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL async_reset_occ got=%0d exp=0", occupancy); end
    model_reset();
    @(posedge clk); #1 rst = 0;
    step();
    checks++; if (occupancy !== 4'd0 || next_inst_id !== 3'd0) begin failures++; $display("FAIL post_reset got occ=%0d id=%0d exp=0/0", occupancy, next_inst_id); end
    checks++; if (ret_valid !== 1'b0 || wb_pc_valid !== 1'b0) begin failures++; $display("FAIL post_reset_pulses got=%b/%b exp=0/0", ret_valid, wb_pc_valid); end
  endtask

  task automatic test_in_order_retire();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
    do_reset();
    alloc(32'h100); alloc(32'h104); alloc(32'h108);
    checks++; if (next_inst_id !== 3'd3 || occupancy !== 4'd3) begin failures++; $display("FAIL inorder_alloc got id=%0d occ=%0d exp=3/3", next_inst_id, occupancy); end
    complete(3'd2, 32'h10c, 5'd0, 1'b0, 32'h0);
    complete(3'd0, 32'h104, 5'd0, 1'b0, 32'h0);
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL inorder_early got=%b exp=0", ret_valid); end
    complete(3'd1, 32'h108, 5'd0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      $display("retire   pc=%h wb=%b", ret_pc, wb_pc_valid);
      checks++; if (ret_valid !== 1'b1 || ret_pc !== exp_pc[i]) begin failures++; $display("FAIL inorder_ret%0d got=%b/%h exp=1/%h", i, ret_valid, ret_pc, exp_pc[i]); end
      checks++; if (wb_pc_valid !== 1'b0) begin failures++; $display("FAIL inorder_wb%0d got=%b exp=0", i, wb_pc_valid); end
      step();
    end
    checks++; if (ret_valid !== 1'b0 || occupancy !== 4'd0) begin failures++; $display("FAIL inorder_drain got=%b/%0d exp=0/0", ret_valid, occupancy); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) alloc(32'h200 + 32'(i * 4));
    checks++; if (inst_buffer_full !== 1'b1 || occupancy !== 4'd8 || next_inst_id !== 3'd0) begin failures++; $display("FAIL full_set got=%b/%0d/%0d exp=1/8/0", inst_buffer_full, occupancy, next_inst_id); end
    alloc(32'h9990);
    checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL full_ignore got=%0d exp=8", occupancy); end
    complete(3'd0, 32'h204, 5'd1, 1'b0, 32'h0);
    inst_alloc = 1; inst_alloc_pc = 32'h9994;
    step();
    checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h200) begin failures++; $display("FAIL full_retire got=%b/%h exp=1/00000200", ret_valid, ret_pc); end
    checks++; if (inst_buffer_full !== 1'b0 || occupancy !== 4'd7 || next_inst_id !== 3'd0) begin failures++; $display("FAIL full_drop got=%b/%0d/%0d exp=0/7/0", inst_buffer_full, occupancy, next_inst_id); end
    alloc(32'h220);
    checks++; if (occupancy !== 4'd8 || next_inst_id !== 3'd1 || inst_buffer_full !== 1'b1) begin failures++; $display("FAIL wrap_alloc got=%0d/%0d/%b exp=8/1/1", occupancy, next_inst_id, inst_buffer_full); end
  endtask

  task automatic test_redirect();
    do_reset();
    alloc(32'h300); alloc(32'h304); alloc(32'h308); alloc(32'h30c);
    complete(3'd1, 32'h200, 5'd2, 1'b1, 32'h11);
    complete(3'd0, 32'h304, 5'd0, 1'b0, 32'h0);
    step();
    checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h300 || wb_pc_valid !== 1'b0) begin failures++; $display("FAIL redir_first got=%b/%h/%b exp=1/00000300/0", ret_valid, ret_pc, wb_pc_valid); end
    complete(3'd2, 32'h30c, 5'd3, 1'b1, 32'h22);
    $display("retire   pc=%h wb=%b wb_pc=%h", ret_pc, wb_pc_valid, wb_pc);
    checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h304 || ret_rd_we !== 1'b1 || ret_rd_val !== 32'h11) begin failures++; $display("FAIL redir_ret got=%b/%h/%b/%h exp=1/00000304/1/00000011", ret_valid, ret_pc, ret_rd_we, ret_rd_val); end
    checks++; if (wb_pc_valid !== 1'b1 || wb_pc !== 32'h200) begin failures++; $display("FAIL redir_wb got=%b/%h exp=1/00000200", wb_pc_valid, wb_pc); end
    checks++; if (occupancy !== 4'd0 || next_inst_id !== 3'd2) begin failures++; $display("FAIL redir_flush got=%0d/%0d exp=0/2", occupancy, next_inst_id); end
  endtask

  // Runs directly after test_redirect while wb_pc_valid is still high.
  task automatic test_wrong_path_drop();
    inst_alloc = 1; inst_alloc_pc = 32'h200;
    cpl_valid = 1; cpl_id = 3'd2; cpl_next_pc = 32'h30c;
    step();
    checks++; if (occupancy !== 4'd0 || next_inst_id !== 3'd2) begin failures++; $display("FAIL drop_state got=%0d/%0d exp=0/2", occupancy, next_inst_id); end
    checks++; if (wb_pc_valid !== 1'b0 || ret_valid !== 1'b0) begin failures++; $display("FAIL drop_pulses got=%b/%b exp=0/0", wb_pc_valid, ret_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ret_valid !== 1'b0 || occupancy !== 4'd0) begin failures++; $display("FAIL drop_quiet%0d got=%b/%0d exp=0/0", i, ret_valid, occupancy); end
    end
    alloc(32'h200);
    checks++; if (occupancy !== 4'd1 || next_inst_id !== 3'd3) begin failures++; $display("FAIL drop_resume got=%0d/%0d exp=1/3", occupancy, next_inst_id); end
  endtask

  task automatic test_rd_write();
    do_reset();
    alloc(32'h400);
    complete(3'd0, 32'h404, 5'd5, 1'b1, 32'hDEAD);
    checks++; if (ret_valid !== 1'b0 || ret_rd_we !== 1'b0) begin failures++; $display("FAIL rd_early got=%b/%b exp=0/0", ret_valid, ret_rd_we); end
    step();
    checks++; if (ret_valid !== 1'b1 || ret_rd !== 5'd5 || ret_rd_we !== 1'b1 || ret_rd_val !== 32'hDEAD) begin failures++; $display("FAIL rd_write got=%b/%0d/%b/%h exp=1/5/1/0000dead", ret_valid, ret_rd, ret_rd_we, ret_rd_val); end
    step();
    checks++; if (ret_valid !== 1'b0 || ret_rd_we !== 1'b0) begin failures++; $display("FAIL rd_gate got=%b/%b exp=0/0", ret_valid, ret_rd_we); end
  endtask

  task automatic test_random();
    int k, nret = 0, nfl = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 55) begin
        inst_alloc = 1; inst_alloc_pc = $urandom() & 32'hFFFF_FFFC;
      end
      if (mq.size() > 0 && $urandom_range(0, 99) < 65) begin
        k = $urandom_range(0, mq.size() - 1);
        if (!mq[k].done) begin
          cpl_valid = 1; cpl_id = mq[k].id;
          cpl_next_pc = ($urandom_range(0, 99) < 85) ? mq[k].pc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
          cpl_rd = 5'($urandom()); cpl_rd_we = 1'($urandom()); cpl_rd_val = $urandom();
        end
      end else if (mq.size() < 8 && $urandom_range(0, 99) < 10) begin
        cpl_valid = 1; cpl_id = m_next_id; cpl_next_pc = $urandom();
      end
      step();
      if (m_ret_valid) nret++;
      if (m_wb_valid) nfl++;
      checks++; if (occupancy !== 4'(mq.size()) || next_inst_id !== m_next_id || inst_buffer_full !== (mq.size() == 8)) begin failures++; $display("FAIL rnd_state c=%0d got occ=%0d id=%0d full=%b exp occ=%0d id=%0d", c, occupancy, next_inst_id, inst_buffer_full, mq.size(), m_next_id); end
      checks++; if (ret_valid !== m_ret_valid || ret_rd_we !== m_ret_we) begin failures++; $display("FAIL rnd_ret c=%0d got=%b/%b exp=%b/%b", c, ret_valid, ret_rd_we, m_ret_valid, m_ret_we); end
      if (m_ret_valid) begin
        checks++; if (ret_pc !== m_ret_pc || ret_rd !== m_ret_rd || ret_rd_val !== m_ret_val) begin failures++; $display("FAIL rnd_data c=%0d got=%h/%0d/%h exp=%h/%0d/%h", c, ret_pc, ret_rd, ret_rd_val, m_ret_pc, m_ret_rd, m_ret_val); end
      end
      checks++; if (wb_pc_valid !== m_wb_valid || wb_pc !== m_wb_pc) begin failures++; $display("FAIL rnd_wb c=%0d got=%b/%h exp=%b/%h", c, wb_pc_valid, wb_pc, m_wb_valid, m_wb_pc); end
    end
    $display("random   retired=%0d flushes=%0d", nret, nfl);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_in_order_retire();
    test_full_wrap();
    test_redirect();
    test_wrong_path_drop();
    test_rd_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mr_retqueue.md
Name: mr_retqueue

Overview:
In-order retire queue (ROB-lite) downstream of the instruction fetch allocation interface. It hands out instruction IDs, records execute completions out of order, and retires one instruction per cycle in program order to the register file. On a retire whose next PC is not pc+4 (fetch always predicts fall-through), it flushes all younger entries and drives the redirect PC back to fetch.

Parameters:
ID_BITS, `INSTID_BITS, ID width; DEPTH = 2**ID_BITS entries (8 for ID_BITS=3)
RESET_VEC, 0, reset value of wb_pc (no redirect is issued at reset)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
inst_alloc  in  1  fetch dispatches one instruction this cycle
inst_alloc_pc  in  `XLEN  PC of the allocated instruction
inst_buffer_full  out  1  queue holds DEPTH entries; allocation refused
next_inst_id  out  ID_BITS  ID the next allocation receives (valid when not full)
cpl_valid  in  1  execute completion strobe
cpl_id  in  ID_BITS  ID being completed
cpl_next_pc  in  `XLEN  architectural next PC of the completed instruction
cpl_rd  in  5  destination register
cpl_rd_we  in  1  destination write enable
cpl_rd_val  in  `XLEN  destination value
ret_valid  out  1  one-cycle retire pulse
ret_pc  out  `XLEN  PC of the retired instruction
ret_rd  out  5  register file write address
ret_rd_we  out  1  register file write enable (gated by ret_valid)
ret_rd_val  out  `XLEN  register file write data
wb_pc  out  `XLEN  redirect target
wb_pc_valid  out  1  one-cycle redirect/flush pulse; also the squash signal for execute
occupancy  out  ID_BITS+1  number of live entries

Behaviour:
- head/tail pointers are ID_BITS+1 bits wide (wrap bit); occupancy = tail-head mod 2**(ID_BITS+1); empty when head==tail; inst_buffer_full = (occupancy==DEPTH), from registered state only.
- next_inst_id = tail[ID_BITS-1:0]. Allocation: inst_alloc & !inst_buffer_full & !wb_pc_valid writes pc, clears done, tail+1. inst_alloc while full: ignored, simulation assertion fires.
- Completion: accepted if cpl_valid & !wb_pc_valid & cpl_id inside [head,tail) & entry not done; stores next_pc/rd/we/val and sets done. Completion outside the window or of an already-done entry is ignored (assertion on the latter).
- Retire: at each edge, if the queue is not empty and the head entry is done, head+1 and ret_* are registered from that entry; ret_valid is high the following cycle only. A completion presented in cycle N retires at the edge ending N+1; ret_valid is high in cycle N+2. Maximum one retire per cycle; back-to-back done entries retire on consecutive cycles.
- Redirect: if the retiring entry has next_pc != pc+4 (`XLEN wrap-around arithmetic), then at the same edge tail <= head+1 (queue empty), all done bits clear, wb_pc <= next_pc, and wb_pc_valid is high for exactly the same cycle as ret_valid. The retiring instruction's register write still occurs.
- While wb_pc_valid is high, allocations and completions are dropped (wrong path). No retire is possible in that cycle because the queue is empty.
- Same-edge alloc and retire when not full: both take effect, so occupancy stays the same. When full, alloc is refused even if a retire happens at that edge.
- Reset (asynchronous, any time): head=tail=0, all done bits 0, ret_valid=0, ret_rd_we=0, ret_pc=0, ret_rd=0, ret_rd_val=0, wb_pc_valid=0, wb_pc=RESET_VEC, occupancy=0, inst_buffer_full=0.

Optional Feature:
MR_RETQ_PERF_EN. When defined, adds output ports perf_retired (64-bit, +1 per ret_valid) and perf_flushes (32-bit, +1 per wb_pc_valid). Both are free-running, wrap on overflow, and clear on rst. When undefined, the ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset mid-run with 3 live entries -> next cycle: occupancy=0, next_inst_id=0, ret_valid=0, wb_pc_valid=0.
- Allocate pc 0x100,0x104,0x108 (ids 0,1,2); complete in order 2,0,1 with next_pc=pc+4 -> three ret_valid pulses in order 0x100,0x104,0x108 on consecutive cycles; no wb_pc_valid.
- Fill 8 entries (ID_BITS=3) -> inst_buffer_full=1; a 9th inst_alloc is ignored; retire one -> full drops, next_inst_id=0 (wrap).
- Alloc ids 0..3; complete id 1 with next_pc=0x200 (taken branch), then id 0 -> id 0 retires, then id 1 retires with wb_pc=0x200 and wb_pc_valid=1 in the same cycle; occupancy=0; a late cpl_id=2 is ignored.
- Same cycle as wb_pc_valid: inst_alloc=1 and cpl_valid=1 -> both dropped; tail unchanged.
- Completion with cpl_rd_we=1, rd=5, val=0xDEAD -> ret_rd=5, ret_rd_we=1, ret_rd_val=0xDEAD exactly 2 cycles after completion when at head.
